// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the ID/EX pipeline register and the
// multiply/divide unit that owns HI/LO.
interface mult_div_unit_if;
    logic        i_start;
    logic [2:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_busy;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    modport master (
        output i_start, i_op, i_a, i_b,
        input  o_busy, o_hi, o_lo
    );

    modport slave (
        input  i_start, i_op, i_a, i_b,
        output o_busy, o_hi, o_lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO; the result is formed from
// latched operands and committed after a fixed per-class latency.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic            i_clk,
    input  logic            i_reset,
    mult_div_unit_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    function automatic logic [31:0] f_neg(input logic [31:0] x);
        return 32'd0 - x;
    endfunction

    function automatic logic [31:0] f_abs(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? f_neg(x) : x;
    endfunction

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [2:0]  r_op, w_op_nxt;
    logic [31:0] r_a, w_a_nxt;
    logic [31:0] r_b, w_b_nxt;
    logic [31:0] r_hi, w_hi_nxt;
    logic [31:0] r_lo, w_lo_nxt;
    logic        r_busy, w_busy_nxt;

    logic        w_is_signed;
    logic        w_is_mult;
    logic [63:0] w_ext_a, w_ext_b, w_prod;
    logic [31:0] w_mag_a, w_mag_b, w_mag_q, w_mag_r, w_quo, w_rem;

    // Signed division works on magnitudes so MIN_INT / -1 wraps cleanly.
    assign w_is_signed = (r_op == OP_MULT) || (r_op == OP_DIV);
    assign w_is_mult   = (r_op == OP_MULT) || (r_op == OP_MULTU);
    assign w_ext_a     = {{32{w_is_signed & r_a[31]}}, r_a};
    assign w_ext_b     = {{32{w_is_signed & r_b[31]}}, r_b};
    assign w_prod      = w_ext_a * w_ext_b;
    assign w_mag_a     = f_abs(r_a, w_is_signed);
    assign w_mag_b     = f_abs(r_b, w_is_signed);
    assign w_mag_q     = (w_mag_b == 32'd0) ? 32'd0 : w_mag_a / w_mag_b;
    assign w_mag_r     = (w_mag_b == 32'd0) ? 32'd0 : w_mag_a % w_mag_b;
    assign w_quo       = (w_is_signed && (r_a[31] ^ r_b[31])) ? f_neg(w_mag_q) : w_mag_q;
    assign w_rem       = (w_is_signed && r_a[31]) ? f_neg(w_mag_r) : w_mag_r;

    // Next-state, operand latch and HI/LO commit decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    case (bus.i_op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            w_op_nxt    = bus.i_op;
                            w_a_nxt     = bus.i_a;
                            w_b_nxt     = bus.i_b;
                            w_state_nxt = ST_RUN;
                            if (bus.i_op[1]) begin
                                w_cnt_nxt = 4'(DIV_CYCLES);
                            end else begin
                                w_cnt_nxt = 4'(MULT_CYCLES);
                            end
                        end
                        OP_MTHI: w_hi_nxt = bus.i_a;
                        OP_MTLO: w_lo_nxt = bus.i_a;
                        default: ;
                    endcase
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_cnt <= 4'd1) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ST_IDLE;
                    if (w_is_mult) begin
                        w_hi_nxt = w_prod[63:32];
                        w_lo_nxt = w_prod[31:0];
                    end else if (r_b != 32'd0) begin
                        w_hi_nxt = w_rem;
                        w_lo_nxt = w_quo;
                    end else begin
                        w_hi_nxt = r_hi;
                        w_lo_nxt = r_lo;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt == ST_RUN);
    end

    // State, operand and result registers; reset discards any in-flight op.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_op    <= 3'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign bus.o_busy = r_busy;
    assign bus.o_hi   = r_hi;
    assign bus.o_lo   = r_lo;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit with the HI/LO result registers, in the EX stage of the pipelined MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the ID/EX pipeline register.
- Asserts busy so hazard control stalls the pipeline.
- Drives HI/LO to the EX result mux for MFHI/MFLO.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, cycles busy stays high for DIV/DIVU (legal range 1..15)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  request; op/A/B valid this cycle
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=reserved (no effect)
- A  input  32  operand rs (also the MTHI/MTLO source)
- B  input  32  operand rt
- busy  output  1  operation in flight
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Reset (asynchronous, active-high, any time, including mid-operation):
  - busy=0, HI=0, LO=0, counter=0.
  - Any in-flight result is discarded.
- States: IDLE, RUN.
- IDLE, start=1, op in {0..3}, at edge T:
  - Latch A, B and op internally.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; busy=1 from edge T.
- RUN, each edge: decrement counter.
  - At the edge where the counter reaches 0, write HI/LO, set busy=0 and return to IDLE.
  - HI/LO change exactly N edges after the start edge (N = latency); busy is high for exactly N cycles.
- IDLE, start=1, op=4 (MTHI) or op=5 (MTLO):
  - HI<=A (or LO<=A) at that edge.
  - busy stays 0; single-cycle.
- IDLE, start=1, op=6/7: no state change.
- RUN, start=1 (any op): ignored entirely; hazard control guarantees it does not occur.
- Latched operands: A/B changing after the start edge do not affect the result.
- HI/LO hold their previous values during RUN; MFHI/MFLO are stalled externally.
- MULT: {HI,LO} = signed(A) * signed(B), full 64-bit product.
- MULTU: {HI,LO} = unsigned 64-bit product.
- DIV (signed):
  - LO = quotient, truncated toward zero.
  - HI = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: LO = A/B, HI = A%B, both unsigned.
- Divide by zero (DIV/DIVU with B=0):
  - Still busy for DIV_CYCLES.
  - HI/LO are left unchanged at completion.
- Back-to-back: a start in the cycle immediately after busy falls is accepted normally.
- Implementation freedom: the result may be computed combinationally from the latched operands or iteratively, but the cycle-level timing above is mandatory.

Test Plan:
- Reset, then MULT A=0xFFFFFFFE (-2), B=3 -> busy high for 5 cycles; at edge 5, HI=0xFFFFFFFF, LO=0xFFFFFFFA, busy=0.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles, HI=0xFFFFFFFE, LO=0x00000001; change A/B during RUN -> result unchanged.
- DIV A=0xFFFFFFF9 (-7), B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=2 -> LO=3, HI=1.
- MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 in consecutive cycles -> HI/LO update on the same edge as each start, busy never asserted. Then DIV B=0 -> busy for 10 cycles, HI/LO still 0x12345678/0x9ABCDEF0.
- Start MULT, issue start DIVU 2 cycles later (ignored) -> MULT result only, at edge 5.
- Start DIV, assert reset asynchronously in cycle 4 (between edges) -> busy/HI/LO = 0 immediately, before the next edge. Release reset, issue MTLO A=5 -> LO=5.
